// File: rtl/osc_freq_monitor.sv
// Oscillator edge-rate monitor: counts osc_in edges per WINDOW clk cycles and flags out-of-range counts.
// Define OSC_MON_BOTHEDGE_EN to count both edges of osc_in instead of rising edges only.
module osc_freq_monitor #(
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             _Reset,
  input  logic             osc_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] min_edges,
  input  logic [CNT_W-1:0] max_edges,
  input  logic             clr_err,
  output logic [CNT_W-1:0] edge_count,
  output logic             valid,
  output logic             too_slow,
  output logic             too_fast,
  output logic             err_sticky
);

  localparam int unsigned WIN_W = $clog2(WINDOW);
  localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   osc_s;
  logic                   osc_prev;
  logic                   edge_det;
  logic [SET_W-1:0]       settle_cnt;
  logic [WIN_W-1:0]       win_cnt;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       acc_inc;
  logic                   last_cycle;

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      sync_q   <= '0;
      osc_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], osc_in};
      osc_prev <= osc_s;
    end
  end

  assign osc_s = sync_q[SYNC_STAGES-1];

`ifdef OSC_MON_BOTHEDGE_EN
  assign edge_det = osc_s ^ osc_prev;
`else
  assign edge_det = osc_s & ~osc_prev;
`endif

  // Saturating increment; also the captured value in the last window cycle.
  assign acc_inc = (edge_det && (acc != '1)) ? acc + CNT_W'(1) : acc;

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    last_cycle = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE: begin
        if (!enable)                      state_nxt = IDLE;
        else if (settle_cnt == SET_LAST)  state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!enable) state_nxt = IDLE;
        else         last_cycle = (win_cnt == WIN_LAST);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      acc        <= '0;
    end else begin
      if (state == SETTLE && settle_cnt != SET_LAST) settle_cnt <= settle_cnt + SET_W'(1);
      else if (state != SETTLE)                      settle_cnt <= '0;

      // Window restarts straight after the last cycle, so no edge slot is lost.
      if (state == MEASURE && enable && !last_cycle) begin
        win_cnt <= win_cnt + WIN_W'(1);
        acc     <= acc_inc;
      end else begin
        win_cnt <= '0;
        acc     <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge _Reset) begin
    if (!_Reset) begin
      edge_count <= '0;
      valid      <= 1'b0;
      too_slow   <= 1'b0;
      too_fast   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      valid <= last_cycle;
      if (last_cycle) begin
        edge_count <= acc_inc;
        too_slow   <= (acc_inc < min_edges);
        too_fast   <= (acc_inc > max_edges);
      end
      if (valid && (too_slow || too_fast)) err_sticky <= 1'b1;
      else if (clr_err)                     err_sticky <= 1'b0;
    end
  end

endmodule
